// File: rtl/conway_life_ctrl.sv
// conway_life_ctrl: run controller for the conway_life grid.
//   Holds a frame buffer that the host writes row by row. On a start request it
//   loads the frame into the grid and lets the grid advance the requested number
//   of generations. A run ends early on abort or still-life. When the run ends,
//   the grid is frozen by reloading it every cycle, and the result is copied back
//   into the frame.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   wr_valid/wr_row/wr_data         host row write into frame (accepted when wr_ready)
//   wr_ready                        1 in IDLE/DONE
//   start_valid/start_gens          run request (accepted when start_ready)
//   start_ready                     1 in IDLE/DONE
//   abort                           stop the run now (only sampled while running)
//   busy                            1 in LOAD/RUN/CAPTURE
//   done/stable/aborted/gens_run    run status, valid while done
//   life_load/life_data             drive the grid load port
//   life_q                          grid state
module conway_life_ctrl #(
   parameter  int unsigned ROWS  = 16,
   parameter  int unsigned COLS  = 16,
   parameter  int unsigned GEN_W = 16,
   localparam int unsigned ROW_W = $clog2(ROWS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_valid,
   input  logic [ROW_W-1:0]       wr_row,
   input  logic [COLS-1:0]        wr_data,
   output logic                   wr_ready,
   input  logic                   start_valid,
   input  logic [GEN_W-1:0]       start_gens,
   output logic                   start_ready,
   input  logic                   abort,
   output logic                   busy,
   output logic                   done,
   output logic                   stable,
   output logic                   aborted,
   output logic [GEN_W-1:0]       gens_run,
   output logic                   life_load,
   output logic [ROWS*COLS-1:0]   life_data,
   input  logic [ROWS*COLS-1:0]   life_q
);

   localparam int unsigned CELLS = ROWS * COLS;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_RUN     = 3'd2,
      S_CAPTURE = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t             state, state_nxt;
   logic [CELLS-1:0]   frame, frame_nxt;
   logic [CELLS-1:0]   last_q, last_q_nxt;
   logic [GEN_W-1:0]   remaining, remaining_nxt;
   logic [GEN_W-1:0]   gens_done, gens_done_nxt;
   logic [GEN_W-1:0]   gens_run_nxt;
   logic               stable_nxt, aborted_nxt;
   logic               ready;
   logic               wr_acc, st_acc;

   assign wr_ready    = ready;
   assign start_ready = ready;
   assign wr_acc      = wr_valid && ready;
   assign st_acc      = start_valid && ready;

   // State and datapath registers; status flags are decoded from the next state
   // so they are flops that line up with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         frame     <= '0;
         last_q    <= '0;
         remaining <= '0;
         gens_done <= '0;
         gens_run  <= '0;
         stable    <= 1'b0;
         aborted   <= 1'b0;
         ready     <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         frame     <= frame_nxt;
         last_q    <= last_q_nxt;
         remaining <= remaining_nxt;
         gens_done <= gens_done_nxt;
         gens_run  <= gens_run_nxt;
         stable    <= stable_nxt;
         aborted   <= aborted_nxt;
         ready     <= (state_nxt == S_IDLE) || (state_nxt == S_DONE);
         busy      <= (state_nxt == S_LOAD) || (state_nxt == S_RUN) ||
                      (state_nxt == S_CAPTURE);
         done      <= (state_nxt == S_DONE);
      end
   end

   // Next-state, datapath updates and grid drive.
   always_comb begin
      state_nxt     = state;
      frame_nxt     = frame;
      last_q_nxt    = last_q;
      remaining_nxt = remaining;
      gens_done_nxt = gens_done;
      gens_run_nxt  = gens_run;
      stable_nxt    = stable;
      aborted_nxt   = aborted;
      life_load     = 1'b1;
      life_data     = frame;

      unique case (state)
         S_IDLE, S_DONE: begin
            // Write lands in the frame on this edge, so a start in the same
            // cycle loads the updated frame from LOAD.
            if (wr_acc) begin
               for (int unsigned r = 0; r < ROWS; r++) begin
                  if (wr_row == ROW_W'(r)) begin
                     frame_nxt[r*COLS +: COLS] = wr_data;
                  end
               end
               if (state == S_DONE) begin
                  state_nxt = S_IDLE;
               end
            end
            if (st_acc) begin
               remaining_nxt = start_gens;
               gens_done_nxt = '0;
               stable_nxt    = 1'b0;
               aborted_nxt   = 1'b0;
               state_nxt     = S_LOAD;
            end
         end

         S_LOAD: begin
            state_nxt = (remaining != '0) ? S_RUN : S_CAPTURE;
         end

         S_RUN: begin
            life_load  = 1'b0;
            last_q_nxt = life_q;
            if (abort) begin
               life_load    = 1'b1;
               life_data    = life_q;
               frame_nxt    = life_q;
               gens_run_nxt = gens_done;
               aborted_nxt  = 1'b1;
               state_nxt    = S_DONE;
            end else if ((gens_done != '0) && (life_q == last_q)) begin
               // Still-life: the last step produced no change.
               life_load    = 1'b1;
               life_data    = life_q;
               frame_nxt    = life_q;
               gens_run_nxt = gens_done;
               stable_nxt   = 1'b1;
               state_nxt    = S_DONE;
            end else begin
               gens_done_nxt = gens_done + GEN_W'(1);
               remaining_nxt = remaining - GEN_W'(1);
               if (remaining == GEN_W'(1)) begin
                  state_nxt = S_CAPTURE;
               end
            end
         end

         S_CAPTURE: begin
            life_data    = life_q;
            frame_nxt    = life_q;
            gens_run_nxt = gens_done;
            state_nxt    = S_DONE;
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_conway_life_ctrl.sv
// tb_conway_life_ctrl: drives conway_life_ctrl against a behavioural grid and
// compares run results with a generation-level reference model.
module tb_conway_life_ctrl;

   localparam int unsigned ROWS  = 16;
   localparam int unsigned COLS  = 16;
   localparam int unsigned GEN_W = 16;
   localparam int unsigned CELLS = ROWS * COLS;
   localparam int          NR    = 16;
   localparam int          NC    = 16;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               wr_valid = 1'b0;
   logic [3:0]         wr_row = '0;
   logic [COLS-1:0]    wr_data = '0;
   logic               wr_ready;
   logic               start_valid = 1'b0;
   logic [GEN_W-1:0]   start_gens = '0;
   logic               start_ready;
   logic               abort = 1'b0;
   logic               busy, done, stable, aborted;
   logic [GEN_W-1:0]   gens_run;
   logic               life_load;
   logic [CELLS-1:0]   life_data;
   logic [CELLS-1:0]   life_q = '0;

   int n_chk = 0;
   int n_err = 0;
   logic [CELLS-1:0] model_frame;

   conway_life_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .wr_valid(wr_valid), .wr_row(wr_row), .wr_data(wr_data), .wr_ready(wr_ready),
      .start_valid(start_valid), .start_gens(start_gens), .start_ready(start_ready),
      .abort(abort), .busy(busy), .done(done), .stable(stable), .aborted(aborted),
      .gens_run(gens_run), .life_load(life_load), .life_data(life_data), .life_q(life_q)
   );

   always #5 clk = ~clk;

   // One Life generation on a 16x16 torus.
   function automatic logic [CELLS-1:0] life_step(input logic [CELLS-1:0] g);
      logic [CELLS-1:0] n;
      int cnt;
      n = '0;
      for (int r = 0; r < NR; r++) begin
         for (int c = 0; c < NC; c++) begin
            cnt = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  if ((dr != 0 || dc != 0) &&
                      g[((r + dr + NR) % NR) * NC + ((c + dc + NC) % NC)]) cnt++;
               end
            end
            n[r*NC + c] = (cnt == 3) || (g[r*NC + c] && cnt == 2);
         end
      end
      return n;
   endfunction

   function automatic logic [CELLS-1:0] shift11(input logic [CELLS-1:0] g);
      logic [CELLS-1:0] s;
      s = '0;
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++)
            s[((r + 1) % NR) * NC + ((c + 1) % NC)] = g[r*NC + c];
      return s;
   endfunction

   // Behavioural grid: reload when asked, otherwise advance.
   always @(posedge clk) life_q <= life_load ? life_data : life_step(life_q);

   task automatic check(input string tag, input logic [CELLS-1:0] got,
                        input logic [CELLS-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic load_and_start(input logic [CELLS-1:0] init, input int gens);
      for (int r = 0; r < NR; r++) begin
         wr_valid = 1'b1;
         wr_row   = 4'(r);
         wr_data  = init[r*NC +: NC];
         if (r == NR - 1) begin
            start_valid = 1'b1;
            start_gens  = GEN_W'(gens);
         end
         @(posedge clk); #1;
      end
      wr_valid    = 1'b0;
      start_valid = 1'b0;
   endtask

   task automatic run_case(input string tag, input logic [CELLS-1:0] init,
                           input int gens, input int abort_at);
      logic [CELLS-1:0] g, gp, q_hold;
      int exp_gens, lat;
      bit exp_st, exp_ab, bad;
      // Reference: generation k is on the grid during running cycle k+1.
      g = init; gp = init; exp_st = 0; exp_ab = 0; exp_gens = gens;
      for (int k = 0; k < gens; k++) begin
         if (abort_at == k + 1) begin exp_ab = 1; exp_gens = k; break; end
         if (k > 0 && g == gp) begin exp_st = 1; exp_gens = k; break; end
         gp = g;
         g  = life_step(g);
      end
      model_frame = g;

      load_and_start(init, gens);
      check({tag, "/busy_after_start"}, CELLS'(busy), CELLS'(1));
      lat = 0; bad = 0;
      for (int k = 1; k <= exp_gens + 20 && lat == 0; k++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            lat = k + 1;
            abort = 1'b0; wr_valid = 1'b0; start_valid = 1'b0;
         end else begin
            if (busy !== 1'b1 || wr_ready !== 1'b0 || start_ready !== 1'b0) bad = 1;
            abort       = (k == abort_at);
            wr_valid    = 1'($urandom_range(0, 1));
            wr_row      = 4'($urandom);
            wr_data     = 16'($urandom);
            start_valid = 1'($urandom_range(0, 1));
            start_gens  = 16'($urandom);
         end
      end
      abort = 1'b0; wr_valid = 1'b0; start_valid = 1'b0;
      check({tag, "/latency"},  CELLS'(lat), CELLS'(exp_gens + 3));
      check({tag, "/holdoff"},  CELLS'(bad), CELLS'(0));
      check({tag, "/frame"},    life_data, model_frame);
      check({tag, "/gens_run"}, CELLS'(gens_run), CELLS'(exp_gens));
      check({tag, "/stable"},   CELLS'(stable), CELLS'(exp_st));
      check({tag, "/aborted"},  CELLS'(aborted), CELLS'(exp_ab));
      // Grid must stay frozen in DONE; abort there has no effect.
      q_hold = life_q; bad = 0;
      for (int i = 0; i < 20; i++) begin
         abort = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         if (life_q !== q_hold || done !== 1'b1 || life_data !== model_frame ||
             life_load !== 1'b1) bad = 1;
      end
      abort = 1'b0;
      check({tag, "/held"},      CELLS'(bad), CELLS'(0));
      check({tag, "/held_grid"}, life_q, model_frame);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      logic [CELLS-1:0] g, e;
      int gens, ab;

      repeat (3) @(posedge clk); #1;
      check("rst_load", CELLS'(life_load), CELLS'(1));
      check("rst_data", life_data, '0);
      check("rst_busy", CELLS'(busy), CELLS'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_flags", CELLS'({busy, done, wr_ready, start_ready, stable, aborted}),
            CELLS'(6'b001100));
      check("idle_gens_run", CELLS'(gens_run), CELLS'(0));

      // Blinker, three generations ends vertical.
      g = '0; g[7*NC +: NC] = 16'h01C0;
      run_case("blinker", g, 3, 0);
      e = '0; e[6*NC +: NC] = 16'h0080; e[7*NC +: NC] = 16'h0080; e[8*NC +: NC] = 16'h0080;
      check("blinker_rows", life_data, e);

      // Block is a still-life.
      g = '0; g[7*NC +: NC] = 16'h0180; g[8*NC +: NC] = 16'h0180;
      run_case("block", g, 100, 0);
      check("block_frame", life_data, g);

      // Glider straddling both wrap edges moves one cell diagonally in 4 gens.
      g = '0;
      g[14*NC + 15] = 1'b1;
      g[15*NC + 0]  = 1'b1;
      g[0*NC + 14]  = 1'b1;
      g[0*NC + 15]  = 1'b1;
      g[0*NC + 0]   = 1'b1;
      run_case("glider", g, 4, 0);
      check("glider_shift", life_data, shift11(g));

      // Long blinker run aborted in the 10th running cycle.
      g = '0; g[7*NC +: NC] = 16'h01C0;
      run_case("abort", g, 1000, 10);

      // Zero generations.
      g = '0; g[3*NC +: NC] = 16'h0F0F; g[9*NC +: NC] = 16'h3C00;
      run_case("zero", g, 0, 0);

      // A write in DONE returns to IDLE and updates the frame.
      e = model_frame; e[3*NC +: NC] = 16'hA5A5;
      wr_valid = 1'b1; wr_row = 4'd3; wr_data = 16'hA5A5;
      @(posedge clk); #1;
      wr_valid = 1'b0;
      check("wr_in_done_done", CELLS'(done), CELLS'(0));
      check("wr_in_done_frame", life_data, e);

      // Random soups, random lengths, occasional abort.
      for (int t = 0; t < 10; t++) begin
         for (int i = 0; i < int'(CELLS / 32); i++) g[i*32 +: 32] = $urandom & $urandom;
         gens = int'($urandom_range(0, 30));
         ab   = (gens > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, gens)) : 0;
         run_case($sformatf("rand%0d", t), g, gens, ab);
      end

      // Reset in the middle of a run.
      g = '0; g[7*NC +: NC] = 16'h01C0;
      load_and_start(g, 1000);
      repeat (6) @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", CELLS'(busy), CELLS'(0));
      check("midrst_data", life_data, '0);
      check("midrst_load", CELLS'(life_load), CELLS'(1));
      repeat (2) @(posedge clk); #1;
      check("midrst_grid", life_q, '0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("midrst_idle", CELLS'({busy, done, wr_ready}), CELLS'(3'b001));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
